// File: rtl/seg_pkg.sv
// Glyph table and decoder shared by the 7-segment encoder and the readback path.
// Segments are active-low: bit0=a .. bit6=g.
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef struct packed {
    logic [3:0] nib;
    logic       blank;
    logic       illegal;
  } seg_dec_t;

  function automatic seg_dec_t seg_decode(input logic [6:0] pat);
    seg_dec_t d;
    d.nib     = 4'h0;
    d.blank   = (pat == SEG_BLANK);
    d.illegal = (pat != SEG_BLANK);
    for (int i = 0; i < 16; i++) begin
      if (pat == SEG_GLYPH[i]) begin
        d.nib     = 4'(i);
        d.illegal = 1'b0;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/seg_readback_filter.sv
// One digit of the readback: input synchroniser, stability filter and glyph decode.
// A digit is stable once its pattern has been seen STABLE_CYCLES times in a row.
module seg_readback_filter
  import seg_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg,
  output logic [3:0] nib,
  output logic       blank,
  output logic       illegal,
  output logic       stable,
  output logic       err
);

  localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [6:0]       sync [SYNC_STAGES];
  logic [6:0]       prev;
  logic [CNT_W-1:0] cnt;
  seg_dec_t         dec;

  // Synchroniser resets to the blank pattern so reset release looks like an unlit display.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync[i] <= SEG_BLANK;
    end else begin
      sync[0] <= seg;
      for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev <= SEG_BLANK;
      cnt  <= '0;
      err  <= 1'b0;
    end else begin
      if (sync[SYNC_STAGES-1] != prev) begin
        prev <= sync[SYNC_STAGES-1];
        cnt  <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
      err <= stable & dec.illegal;
    end
  end

  assign dec     = seg_decode(prev);
  assign stable  = (cnt == CNT_MAX);
  assign nib     = dec.nib;
  assign blank   = dec.blank;
  assign illegal = dec.illegal;

endmodule

// File: rtl/seg_readback.sv
// Reads six active-low 7-segment buses back into a 24-bit hex word, emitting a
// snapshot on valid/ready whenever the stable display content changes.
module seg_readback
  import seg_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int MISS_W        = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [6:0]        SEG0,
  input  logic [6:0]        SEG1,
  input  logic [6:0]        SEG2,
  input  logic [6:0]        SEG3,
  input  logic [6:0]        SEG4,
  input  logic [6:0]        SEG5,
  output logic [23:0]       word_o,
  output logic [5:0]        blank_o,
  output logic              word_valid,
  input  logic              word_ready,
  output logic [5:0]        err_o,
  output logic [MISS_W-1:0] missed_o
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] PEND = 1'b1;

  logic [6:0]  seg_in [6];
  logic [23:0] cand_word;
  logic [5:0]  cand_blank;
  logic [5:0]  illegal;
  logic [5:0]  stable;
  logic [29:0] cand;
  logic        eligible;

  logic [0:0]  state;
  logic [29:0] last_emitted;
  logic        has_emitted;
  logic [29:0] last_missed;
  logic        has_missed;

  assign seg_in[0] = SEG0;
  assign seg_in[1] = SEG1;
  assign seg_in[2] = SEG2;
  assign seg_in[3] = SEG3;
  assign seg_in[4] = SEG4;
  assign seg_in[5] = SEG5;

  for (genvar g = 0; g < 6; g++) begin : g_digit
    seg_readback_filter #(
      .SYNC_STAGES  (SYNC_STAGES),
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_filter (
      .clk    (clk),
      .rst    (rst),
      .seg    (seg_in[g]),
      .nib    (cand_word[4*g +: 4]),
      .blank  (cand_blank[g]),
      .illegal(illegal[g]),
      .stable (stable[g]),
      .err    (err_o[g])
    );
  end

  // Combinational illegal flag gates eligibility so a bad glyph never reaches the handshake.
  assign eligible = (&stable) & ~(|illegal);
  assign cand     = {cand_word, cand_blank};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      word_o       <= '0;
      blank_o      <= '0;
      word_valid   <= 1'b0;
      last_emitted <= '0;
      has_emitted  <= 1'b0;
      last_missed  <= '0;
      has_missed   <= 1'b0;
      missed_o     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (eligible && (!has_emitted || cand != last_emitted)) begin
            word_o       <= cand_word;
            blank_o      <= cand_blank;
            word_valid   <= 1'b1;
            last_emitted <= cand;
            has_emitted  <= 1'b1;
            state        <= PEND;
          end
        end
        PEND: begin
          if (word_ready) begin
            word_valid <= 1'b0;
            state      <= IDLE;
          end
          // Each distinct superseding snapshot is counted once, even on the handshake cycle.
          if (eligible && cand != last_emitted && !(has_missed && cand == last_missed)) begin
            if (missed_o != {MISS_W{1'b1}}) missed_o <= missed_o + 1'b1;
            last_missed <= cand;
            has_missed  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
